// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: scan-code FIFO feeding an 11-bit device-to-host frame serializer.
// Optional define PS2_KBD_TX_ERR_INJ_EN adds err_inj, which inverts the parity bit of the frame being loaded.
module ps2_kbd_tx #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8,
    parameter int DEPTH   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
`ifdef PS2_KBD_TX_ERR_INJ_EN
    input  logic                       err_inj,
`endif
    output logic                       in_ready,
    output logic                       ps2_clk,
    output logic                       ps2_data,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    // state | meaning
    // IDLE  | lines high, waiting for a buffered byte
    // HIGH  | ps2_clk high, current bit driven on ps2_data
    // LOW   | ps2_clk low, ps2_data held for the host to sample
    // GAP   | lines high between frames
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [CW-1:0] CNT_HALF  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_GAP   = CW'(GAP_CYC - 1);

    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [LW-1:0]  level;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     bit_idx;
    logic [10:0]    shreg;

    logic           push;
    logic           pop;
    logic           inj;
    logic [7:0]     head;
    logic           parity;
    logic [10:0]    frame;

`ifdef PS2_KBD_TX_ERR_INJ_EN
    assign inj = err_inj;
`else
    assign inj = 1'b0;
`endif

    assign in_ready   = (level != LVL_FULL);
    assign fifo_level = level;
    assign busy       = (state != S_IDLE);

    assign push   = in_valid && in_ready;
    assign pop    = (state == S_IDLE) && (level != '0);
    assign head   = mem[rd_ptr];
    assign parity = (~^head) ^ inj;
    assign frame  = {1'b1, parity, head, 1'b0};

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // ps2_data only moves on the edge that raises ps2_clk, so it is stable at every falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (pop) begin
                        shreg    <= frame;
                        cnt      <= '0;
                        bit_idx  <= '0;
                        ps2_data <= frame[0];
                        state    <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b0;
                        state   <= S_LOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_LOW: begin
                    if (cnt == CNT_HALF) begin
                        cnt     <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx == 4'd10) begin
                            ps2_data <= 1'b1;
                            state    <= S_GAP;
                        end else begin
                            bit_idx  <= bit_idx + 1'b1;
                            shreg    <= {1'b1, shreg[10:1]};
                            ps2_data <= shreg[1];
                            state    <= S_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                    if (cnt == CNT_GAP) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Keyboard-side PS/2 device model and transmitter. It accepts scan-code bytes over a valid/ready push port and buffers them in a small FIFO. Each byte is serialized as an 11-bit PS/2 device-to-host frame on `ps2_clk`/`ps2_data`. It sits directly upstream of the APB PS/2 receiver in the SoC perip tree and drives that receiver's `ps2_clk`/`ps2_data` inputs for keyboard stimulus on simulation and FPGA builds.

## Interface
- `CLK_DIV`, 4: system clocks per `ps2_clk` half-period. Must be ≥ 2.
- `GAP_CYC`, 8: idle system clocks between frames, with `ps2_clk` and `ps2_data` high. Must be ≥ 1.
- `DEPTH`, 4: FIFO entries. Power of 2, ≥ 2.
- `clock` input 1: system clock. All logic is on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: a byte is offered on `in_data`.
- `in_data` input 8: scan-code byte.
- `in_ready` output 1: FIFO not full. A push occurs on an edge where `in_valid && in_ready`.
- `ps2_clk` output 1: PS/2 clock. Idle high.
- `ps2_data` output 1: PS/2 data. Idle high.
- `busy` output 1: a frame or inter-frame gap is in progress.
- `fifo_level` output $clog2(DEPTH)+1: number of bytes currently buffered.

## Operation
- **FIFO**
  - Read and write pointers of $clog2(DEPTH) bits that wrap naturally; occupancy is held in a separate counter.
  - `in_ready` = (level != DEPTH), decoded from the registered level.
  - While full, a pop on the same edge does not admit a push.
  - A push and a pop on the same edge leave the level unchanged.
- **Frame:** bits are sent in this order:
  - bit0 = start bit, 0.
  - bits 1–8 = data, LSB first.
  - bit9 = odd parity, equal to ~^data.
  - bit10 = stop bit, 1.
- **States:**
  - **IDLE:** `ps2_clk` = 1, `ps2_data` = 1. If the FIFO is non-empty: pop, load the 11-bit shift register, clear the half-period counter and bit index, then go to HIGH.
  - **HIGH:** `ps2_data` = current bit and `ps2_clk` = 1 for CLK_DIV cycles, then go to LOW.
  - **LOW:** `ps2_clk` = 0 for CLK_DIV cycles and `ps2_data` is held. At the end of the phase:
    - if bit index = 10, go to GAP;
    - otherwise increment the index, shift, and go to HIGH.
  - **GAP:** `ps2_clk` = 1, `ps2_data` = 1 for GAP_CYC cycles, then go to IDLE.
- `busy` = (state != IDLE).
- `ps2_data` only changes while `ps2_clk` is high. It is therefore stable across every falling edge, which is the receiver's sample point.
- Bytes are sent strictly in push order; there is no drop and no reorder.

## Timing
- **Reset values:**
  - `ps2_clk` = 1, `ps2_data` = 1, `busy` = 0, `fifo_level` = 0, `in_ready` = 1.
  - State = IDLE; pointers and counters = 0.
  - `ps2_clk` and `ps2_data` are registered with async set, so both go high immediately when `reset` asserts.
- **Reset mid-frame:** the frame is truncated and the FIFO contents are discarded. The receiver sees fewer than 11 falling edges; recovering from that is the receiver's responsibility.
- **Push-to-wire latency from IDLE with an empty FIFO:**
  - Push accepted at edge t.
  - IDLE pops at edge t+1.
  - `ps2_data` falls to 0 at edge t+1. This is the registered output of the load, with `busy` = 1 in the same cycle.
  - First `ps2_clk` fall occurs at edge t+1+CLK_DIV.
- **Frame and gap lengths:**
  - Frame = 22·CLK_DIV cycles from the start bit to `ps2_clk` rising after bit 10.
  - Frame plus gap = 22·CLK_DIV + GAP_CYC cycles.
  - IDLE takes one extra cycle before the next frame.
- **Back-to-back frames:** with the FIFO non-empty, successive start bits are 22·CLK_DIV + GAP_CYC + 1 cycles apart.
- **Falling-edge count:** exactly 11 `ps2_clk` falling edges per frame.

## Configuration
- **`PS2_KBD_TX_ERR_INJ_EN` defined:**
  - Adds input port `err_inj` (1 bit).
  - `err_inj` is sampled on the edge IDLE loads a frame. If it is 1, the parity bit of that frame is inverted.
  - A parity-checking receiver must discard that frame.
- **`PS2_KBD_TX_ERR_INJ_EN` undefined:** the port is absent and parity is always correct.

## Test plan
- **Single byte, CLK_DIV=4:** push 0x1C.
  - `ps2_data` at the 11 `ps2_clk` falls = 0,0,0,1,1,1,0,0,0,0,1 (start, data LSB first, parity 0, stop).
  - Receiver FIFO holds 0x1C; frame spans 88 cycles.
- **Parity extremes:** push 0x00, then 0xFF.
  - Parity bit is 1 for both.
  - Receiver reads 0x00 then 0xFF.
  - Start bits are exactly 88+8+1 = 97 cycles apart.
- **Full FIFO:** hold `in_valid` high with bytes 0x01..0x06 back-to-back, DEPTH=4.
  - `in_ready` drops once `fifo_level` = 4.
  - All six bytes are eventually sent in order, with no duplicates.
- **Reset mid-frame:** assert `reset` low during bit 5 of 0xAA.
  - `ps2_clk`/`ps2_data` go high with no clock edge; `fifo_level` = 0.
  - After release, pushing 0x55 produces one correct frame.
- **Error injection (macro on):** push 0x1C with `err_inj` = 1, then 0x32 with `err_inj` = 0.
  - Parity of the first frame is 1.
  - Receiver delivers only 0x32.
- **Idle stability:** no pushes for 1000 cycles.
  - `ps2_clk` = `ps2_data` = 1 throughout; `busy` = 0.
